ipsl_pcie_ext_rcvd_pkt_fifo: RTL and testbench

Single-clock, parametrised receive packet FIFO for the PCIe extension datapath. It replaces the fixed 72x1024 receive RAM with a store-and-forward buffer that adds read/write pointer management, packet commit and discard, and a first-word-fall-through valid/ready read port. It sits between the TLP receive parser (write side) and the DMA/user logic (read side). In PKT_MODE=0 it degrades to a plain synchronous FWFT FIFO.

---
 rtl/ipsl_pcie_ext_pkg.sv | 24 ++
 rtl/ipsl_pcie_ext_sdpram_gen.sv | 35 +++
 rtl/ipsl_pcie_ext_rcvd_pkt_fifo.sv | 133 +++++++++++++
 tb/tb_ipsl_pcie_ext_rcvd_pkt_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ipsl_pcie_ext_pkg.sv
// rtl/ipsl_pcie_ext_pkg.sv - shared constants and pointer arithmetic for the receive packet FIFO
package ipsl_pcie_ext_pkg;

  // RAM read latency: one array register plus the optional output register.
  function automatic int rd_lat(input int output_reg);
    return (output_reg != 0) ? 2 : 1;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Free RAM entries given two pointers that wrap modulo 2**ptr_w.
  function automatic logic [31:0] free_space(input logic [31:0] depth,
                                             input logic [31:0] wr_ptr,
                                             input logic [31:0] rd_ptr,
                                             input int          ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return depth - ((wr_ptr - rd_ptr) & mask);
  endfunction

endpackage

// File: rtl/ipsl_pcie_ext_sdpram_gen.sv
// rtl/ipsl_pcie_ext_sdpram_gen.sv - single-clock simple dual-port RAM with optional output register
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata valid 1+OUTPUT_REG edges after re.
module ipsl_pcie_ext_sdpram_gen #(
  parameter int WIDTH      = 73,
  parameter int ADDR_WIDTH = 10,
  parameter int OUTPUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q1 <= mem[raddr];
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] q2;
      always_ff @(posedge clk) q2 <= q1;
      assign rdata = q2;
    end else begin : g_noreg
      assign rdata = q1;
    end
  endgenerate

endmodule

// File: rtl/ipsl_pcie_ext_rcvd_pkt_fifo.sv
// rtl/ipsl_pcie_ext_rcvd_pkt_fifo.sv - store-and-forward receive packet FIFO with FWFT read port
// Ports: clk, rst_n (sync, active low); write side wr_en/wr_data/wr_last/wr_drop -> wr_full/wr_afull/pkt_dropped;
//        read side rd_valid/rd_data/rd_last with rd_ready; used_cnt = committed words not yet consumed.
module ipsl_pcie_ext_rcvd_pkt_fifo
  import ipsl_pcie_ext_pkg::*;
#(
  parameter int DATA_WIDTH   = 72,
  parameter int ADDR_WIDTH   = 10,
  parameter int OUTPUT_REG   = 1,
  parameter int PKT_MODE     = 1,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  wr_full,
  output logic                  wr_afull,
  output logic                  pkt_dropped,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [ADDR_WIDTH:0]   used_cnt
);

  localparam int RD_LAT = rd_lat(OUTPUT_REG);
  localparam int PW     = ptr_width(ADDR_WIDTH);
  localparam int QD     = RD_LAT + 1;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int W      = DATA_WIDTH + 1;

  logic [PW-1:0]     wr_ptr, cm_ptr, rd_ptr, acc_ptr;
  logic [PW-1:0]     wr_ptr_nxt, cm_ptr_nxt, acc_ptr_nxt;
  logic              discard;
  logic [RD_LAT-1:0] inflight;
  logic [W-1:0]      q_mem [0:QD-1];
  logic [1:0]        q_rd, q_wr;
  logic [2:0]        q_cnt, fl_cnt;
  logic [W-1:0]      ram_rdata;
  logic              in_pkt, drop_now, ovf_drop, accept, commit, issue, pop, push;

  assign wr_full  = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign wr_afull = free_space(32'(DEPTH), 32'(wr_ptr), 32'(rd_ptr), PW) <= 32'(AFULL_THRESH);

  // Only packet mode has an uncommitted region that a drop can rewind.
  assign in_pkt   = (PKT_MODE != 0) && (wr_ptr != cm_ptr);
  assign drop_now = wr_drop && in_pkt;
  assign ovf_drop = (PKT_MODE != 0) && wr_en && wr_full && in_pkt && !wr_drop && !discard;
  assign accept   = wr_en && !wr_full && !wr_drop && !discard;
  assign commit   = accept && wr_last;

  assign rd_valid = (q_cnt != 3'd0);
  assign rd_data  = q_mem[q_rd][DATA_WIDTH-1:0];
  assign rd_last  = q_mem[q_rd][DATA_WIDTH];
  assign pop      = rd_valid && rd_ready;
  assign push     = inflight[RD_LAT-1];

  always_comb begin
    fl_cnt = 3'd0;
    for (int i = 0; i < RD_LAT; i++) fl_cnt = fl_cnt + {2'b00, inflight[i]};
  end

  // The slot freed by this cycle's pop is reusable, so a full skid queue
  // still sustains one word per cycle with rd_ready held high.
  assign issue = (rd_ptr != cm_ptr) && ((q_cnt + fl_cnt - {2'b00, pop}) < 3'(QD));

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    if (drop_now || ovf_drop) wr_ptr_nxt = cm_ptr;
    else if (accept)          wr_ptr_nxt = wr_ptr + PW'(1);
    cm_ptr_nxt = cm_ptr;
    if (PKT_MODE == 0)        cm_ptr_nxt = wr_ptr_nxt;
    else if (commit)          cm_ptr_nxt = wr_ptr + PW'(1);
    acc_ptr_nxt = acc_ptr + PW'(pop);
  end

  ipsl_pcie_ext_sdpram_gen #(
    .WIDTH      (W),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata ({wr_last, wr_data}),
    .re    (issue),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      rd_ptr      <= '0;
      acc_ptr     <= '0;
      used_cnt    <= '0;
      discard     <= 1'b0;
      pkt_dropped <= 1'b0;
      inflight    <= '0;
      q_rd        <= 2'd0;
      q_wr        <= 2'd0;
      q_cnt       <= 3'd0;
      for (int i = 0; i < QD; i++) q_mem[i] <= '0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      cm_ptr      <= cm_ptr_nxt;
      acc_ptr     <= acc_ptr_nxt;
      used_cnt    <= cm_ptr_nxt - acc_ptr_nxt;
      pkt_dropped <= drop_now || ovf_drop;
      rd_ptr      <= rd_ptr + PW'(issue);

      // A write that finds the RAM full abandons the rest of its packet up to wr_last.
      if (wr_drop)                                  discard <= 1'b0;
      else if (discard)                             discard <= !(wr_en && wr_last);
      else if ((PKT_MODE != 0) && wr_en && wr_full) discard <= !wr_last;

      inflight[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) inflight[i] <= inflight[i-1];

      if (push) begin
        q_mem[q_wr] <= ram_rdata;
        q_wr        <= (q_wr == 2'(QD-1)) ? 2'd0 : q_wr + 2'd1;
      end
      if (pop) q_rd <= (q_rd == 2'(QD-1)) ? 2'd0 : q_rd + 2'd1;
      q_cnt <= q_cnt + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_ipsl_pcie_ext_rcvd_pkt_fifo.sv
// tb/tb_ipsl_pcie_ext_rcvd_pkt_fifo.sv - scoreboard bench for the receive packet FIFO
module tb_ipsl_pcie_ext_rcvd_pkt_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, wr_last, wr_drop, rd_ready;
  logic [15:0] wr_data;
  logic        wr_full, wr_afull, pkt_dropped, rd_valid, rd_last;
  logic [15:0] rd_data;
  logic [4:0]  used_cnt;

  logic        z_wr_en, z_wr_last, z_wr_drop, z_rd_ready;
  logic [15:0] z_wr_data;
  logic        b_full, b_afull, b_drop, b_valid, b_last;
  logic [15:0] b_data;
  logic [4:0]  b_used;
  logic        c_full, c_afull, c_drop, c_valid, c_last;
  logic [15:0] c_data;
  logic [4:0]  c_used;

  always #5 clk = ~clk;

  ipsl_pcie_ext_rcvd_pkt_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUTPUT_REG(1), .PKT_MODE(1), .AFULL_THRESH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_drop(wr_drop),
    .wr_full(wr_full), .wr_afull(wr_afull), .pkt_dropped(pkt_dropped), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .used_cnt(used_cnt));

  ipsl_pcie_ext_rcvd_pkt_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUTPUT_REG(1), .PKT_MODE(0), .AFULL_THRESH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(z_wr_en), .wr_data(z_wr_data), .wr_last(z_wr_last), .wr_drop(z_wr_drop),
    .wr_full(b_full), .wr_afull(b_afull), .pkt_dropped(b_drop), .rd_valid(b_valid),
    .rd_ready(z_rd_ready), .rd_data(b_data), .rd_last(b_last), .used_cnt(b_used));

  ipsl_pcie_ext_rcvd_pkt_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUTPUT_REG(0), .PKT_MODE(0), .AFULL_THRESH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(z_wr_en), .wr_data(z_wr_data), .wr_last(z_wr_last), .wr_drop(z_wr_drop),
    .wr_full(c_full), .wr_afull(c_afull), .pkt_dropped(c_drop), .rd_valid(c_valid),
    .rd_ready(z_rd_ready), .rd_data(c_data), .rd_last(c_last), .used_cnt(c_used));

  int n_checks = 0;
  int n_pass   = 0;
  int drop_cnt = 0;
  int max_used = 0;
  logic [16:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [16:0] hold_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (pkt_dropped) drop_cnt++;
      if (int'(used_cnt) > max_used) max_used = int'(used_cnt);
      if (hold_v) check("stall_stable", 32'({rd_valid, rd_last, rd_data}), 32'({1'b1, hold_w}));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got 0x%0h expected no word", {rd_last, rd_data});
        end else begin
          check("rd_word", 32'({rd_last, rd_data}), 32'(exp_q.pop_front()));
        end
      end
      hold_v = rd_valid && !rd_ready;
      hold_w = {rd_last, rd_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word; with flow=1 it waits out wr_full, with flow=0 it writes regardless.
  task automatic put(input logic [15:0] d, input logic last, input bit flow);
    int guard = 0;
    while (flow && wr_full && guard < 300) begin
      wr_en = 1'b0;
      tick();
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      $display("FAIL put_timeout: got wr_full stuck expected release");
    end
    wr_en = 1'b1; wr_data = d; wr_last = last;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      tick();
      g++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, lb, lc, d0;
    rst_n = 1'b0; wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; wr_data = '0; rd_ready = 1'b1;
    z_wr_en = 1'b0; z_wr_last = 1'b0; z_wr_drop = 1'b0; z_wr_data = '0; z_rd_ready = 1'b1;
    repeat (3) tick();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'({rd_last, rd_data}), 32'd0);
    check("rst_used",     32'(used_cnt), 32'd0);
    check("rst_flags",    32'({wr_full, wr_afull, pkt_dropped}), 32'd0);
    check("rst_b_c",      32'({b_valid, c_valid, b_used, c_used}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 4-word packet, commit-to-valid latency and used_cnt 4 -> 0
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({(i == 4) ? 1'b1 : 1'b0, 16'(i)});
      put(16'(i), (i == 4) ? 1'b1 : 1'b0, 1'b1);
    end
    check("t1_used_commit", 32'(used_cnt), 32'd4);
    check("t1_valid_early", 32'(rd_valid), 32'd0);
    lat = 0;
    while (!rd_valid && lat < 20) begin tick(); lat++; end
    check("t1_latency", 32'(lat), 32'd3);
    drain("t1_drain");
    check("t1_used_end", 32'(used_cnt), 32'd0);

    // partial packet dropped, then a 2-word packet
    max_used = 0;
    d0 = drop_cnt;
    for (int i = 0; i < 3; i++) put(16'h31 + 16'(i), 1'b0, 1'b1);
    wr_drop = 1'b1;
    tick();
    check("t2_drop_pulse", 32'(pkt_dropped), 32'd1);
    wr_drop = 1'b0;
    tick();
    check("t2_drop_end", 32'(pkt_dropped), 32'd0);
    exp_q.push_back({1'b0, 16'h000A});
    exp_q.push_back({1'b1, 16'h000B});
    put(16'h000A, 1'b0, 1'b1);
    put(16'h000B, 1'b1, 1'b1);
    drain("t2_drain");
    check("t2_drop_count", 32'(drop_cnt - d0), 32'd1);
    check("t2_max_used", 32'(max_used), 32'd2);

    // 20-word packet into a 16-deep RAM overflows and is discarded
    for (int i = 1; i <= 20; i++) begin
      put(16'h0100 + 16'(i), (i == 20) ? 1'b1 : 1'b0, 1'b0);
      if (i == 11) check("t3_afull_11", 32'(wr_afull), 32'd0);
      if (i == 12) check("t3_afull_12", 32'(wr_afull), 32'd1);
      if (i == 15) check("t3_full_15", 32'(wr_full), 32'd0);
      if (i == 16) check("t3_full_16", 32'(wr_full), 32'd1);
      if (i == 17) check("t3_ovf_drop", 32'({pkt_dropped, wr_full}), 32'b10);
    end
    repeat (5) tick();
    check("t3_nothing_readable", 32'({rd_valid, wr_afull, used_cnt}), 32'd0);
    exp_q.push_back({1'b0, 16'h0021});
    exp_q.push_back({1'b1, 16'h0022});
    put(16'h0021, 1'b0, 1'b1);
    put(16'h0022, 1'b1, 1'b1);
    drain("t3_drain");

    // back-to-back 16-word packets with rd_ready toggling, across pointer wrap
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          exp_q.push_back({(i % 16 == 15) ? 1'b1 : 1'b0, 16'h4000 + 16'(i)});
          put(16'h4000 + 16'(i), (i % 16 == 15) ? 1'b1 : 1'b0, 1'b1);
        end
      end
      begin
        rd_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
          tick();
          rd_ready = ~rd_ready;
        end
      end
    join
    rd_ready = 1'b1;
    drain("t4_drain");
    check("t4_used_end", 32'(used_cnt), 32'd0);

    // PKT_MODE=0, single word, OUTPUT_REG=1 (b) and OUTPUT_REG=0 (c)
    z_wr_en = 1'b1; z_wr_data = 16'h0055;
    tick();
    z_wr_en = 1'b0;
    check("pm0_used", 32'({b_used, c_used}), 32'({5'd1, 5'd1}));
    lb = 0; lc = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      if (b_valid && lb == 0) begin lb = cyc; check("pm0_b_word", 32'({b_last, b_data}), 32'h55); end
      if (c_valid && lc == 0) begin lc = cyc; check("pm0_c_word", 32'({c_last, c_data}), 32'h55); end
    end
    check("pm0_b_latency", 32'(lb), 32'd3);
    check("pm0_c_latency", 32'(lc), 32'd2);
    check("pm0_used_end", 32'({b_used, c_used, b_valid, c_valid}), 32'd0);

    // reset mid-packet with 5 committed words held back by rd_ready=0
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) put(16'h0060 + 16'(i), (i == 5) ? 1'b1 : 1'b0, 1'b1);
    put(16'h0066, 1'b0, 1'b1);
    put(16'h0067, 1'b0, 1'b1);
    repeat (4) tick();
    check("t6_used_pre", 32'(used_cnt), 32'd5);
    check("t6_head_pre", 32'({rd_valid, rd_last, rd_data}), 32'({1'b1, 1'b0, 16'h0061}));
    rst_n = 1'b0;
    tick();
    check("t6_rst_state", 32'({rd_valid, wr_full, pkt_dropped, used_cnt}), 32'd0);
    check("t6_rst_data", 32'({rd_last, rd_data}), 32'd0);
    rst_n = 1'b1;
    rd_ready = 1'b1;
    tick();
    check("t6_no_pulse", 32'(pkt_dropped), 32'd0);
    exp_q.push_back({1'b0, 16'h0071});
    exp_q.push_back({1'b1, 16'h0072});
    put(16'h0071, 1'b0, 1'b1);
    put(16'h0072, 1'b1, 1'b1);
    drain("t6_drain");
    repeat (5) tick();
    check("final_idle", 32'({rd_valid, used_cnt}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
